// File: rtl/led_ctrl_pkg.sv
// Shared encodings for the LED pattern sequencer: pattern modes, FSM states
// and command field widths.
package led_ctrl_pkg;

    localparam int MODE_W  = 3;
    localparam int SPEED_W = 4;

    typedef enum logic [MODE_W-1:0] {
        MODE_OFF    = 3'd0,
        MODE_LEFT   = 3'd1,
        MODE_RIGHT  = 3'd2,
        MODE_BOUNCE = 3'd3,
        MODE_BLINK  = 3'd4,
        MODE_FILL   = 3'd5
    } mode_e;

    typedef enum logic [1:0] {
        S_OFF  = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2
    } state_e;

    // True for modes that actually step; OFF and the reserved codes 6/7 do not.
    function automatic logic mode_runs(input logic [MODE_W-1:0] m);
        return (m >= MODE_LEFT) && (m <= MODE_FILL);
    endfunction

endpackage

// File: rtl/led_step_gen.sv
// Two-stage prescaler: a base tick every TICK_DIV cycles, and a step event
// every (speed+1) base ticks. The step output is decoded from the counters so
// the parent can update its registers on the very edge the step lands.
module led_step_gen
    import led_ctrl_pkg::*;
#(
    parameter int TICK_DIV = 50000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               enable,
    input  logic [SPEED_W-1:0] speed,
    output logic               step
);

    localparam int TICK_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    logic [TICK_W-1:0]  tick_cnt_q, tick_cnt_d;
    logic [SPEED_W-1:0] div_cnt_q, div_cnt_d;
    logic               tick_wrap;

    assign tick_wrap = enable && (tick_cnt_q == TICK_W'(TICK_DIV - 1));
    assign step      = tick_wrap && (div_cnt_q == speed);

    // Next-state for both counters; clear has priority over counting.
    always_comb begin
        tick_cnt_d = tick_cnt_q;
        div_cnt_d  = div_cnt_q;
        if (clear) begin
            tick_cnt_d = '0;
            div_cnt_d  = '0;
        end else if (enable) begin
            if (tick_wrap) begin
                tick_cnt_d = '0;
                div_cnt_d  = (div_cnt_q == speed) ? '0 : div_cnt_q + SPEED_W'(1);
            end else begin
                tick_cnt_d = tick_cnt_q + TICK_W'(1);
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt_q <= '0;
            div_cnt_q  <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            div_cnt_q  <= div_cnt_d;
        end
    end

endmodule

// File: rtl/led_pattern_ctrl.sv
// LED bank sequencer: accepts mode/speed commands over valid/ready, reloads
// the selected pattern through a one-cycle LOAD state, then advances it on
// each step event from the prescaler.
module led_pattern_ctrl
    import led_ctrl_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int TICK_DIV = 50000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [MODE_W-1:0]  cmd_mode,
    input  logic [SPEED_W-1:0] cmd_speed,
    output logic [WIDTH-1:0]   ledout,
    output logic [MODE_W-1:0]  cur_mode,
    output logic               step_pulse
);

    state_e              state_q, state_d;
    logic [MODE_W-1:0]   mode_q, mode_d;        // raw mode captured at accept
    logic [SPEED_W-1:0]  speed_q, speed_d;
    mode_e               cur_mode_q, cur_mode_d;
    logic [WIDTH-1:0]    pat_q, pat_d;
    logic                dir_right_q, dir_right_d;
    logic                pulse_q, pulse_d;
    logic                accept;
    logic                step;

    function automatic logic [WIDTH-1:0] init_pattern(input logic [MODE_W-1:0] m);
        case (m)
            MODE_LEFT, MODE_BOUNCE, MODE_FILL: return WIDTH'(1);
            MODE_RIGHT:                        return {1'b1, {(WIDTH-1){1'b0}}};
            MODE_BLINK:                        return '1;
            default:                           return '0;
        endcase
    endfunction

    assign cmd_ready  = (state_q != S_LOAD);
    assign accept     = cmd_valid && cmd_ready;
    assign ledout     = pat_q;
    assign cur_mode   = cur_mode_q;
    assign step_pulse = pulse_q;

    led_step_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_step_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (state_q != S_RUN),
        .enable (state_q == S_RUN),
        .speed  (speed_q),
        .step   (step)
    );

    // FSM next-state, command capture and pattern stepping. An accept always
    // wins over a coincident step, which is then dropped.
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        speed_d     = speed_q;
        cur_mode_d  = cur_mode_q;
        pat_d       = pat_q;
        dir_right_d = dir_right_q;
        pulse_d     = 1'b0;

        case (state_q)
            S_LOAD: begin
                pat_d       = init_pattern(mode_q);
                dir_right_d = 1'b0;
                if (mode_runs(mode_q)) begin
                    cur_mode_d = mode_e'(mode_q);
                    state_d    = S_RUN;
                end else begin
                    cur_mode_d = MODE_OFF;
                    state_d    = S_OFF;
                end
            end
            S_RUN: begin
                if (step && !accept) begin
                    pulse_d = 1'b1;
                    case (cur_mode_q)
                        MODE_LEFT:  pat_d = {pat_q[WIDTH-2:0], pat_q[WIDTH-1]};
                        MODE_RIGHT: pat_d = {pat_q[0], pat_q[WIDTH-1:1]};
                        MODE_BOUNCE: begin
                            if (!dir_right_q && pat_q[WIDTH-1]) begin
                                pat_d       = pat_q >> 1;
                                dir_right_d = 1'b1;
                            end else if (dir_right_q && pat_q[0]) begin
                                pat_d       = pat_q << 1;
                                dir_right_d = 1'b0;
                            end else if (dir_right_q) begin
                                pat_d = pat_q >> 1;
                            end else begin
                                pat_d = pat_q << 1;
                            end
                        end
                        MODE_BLINK: pat_d = ~pat_q;
                        MODE_FILL:  pat_d = (&pat_q) ? WIDTH'(1)
                                                     : ((pat_q << 1) | WIDTH'(1));
                        default:    pat_d = '0;
                    endcase
                end
            end
            default: ;
        endcase

        if (accept) begin
            mode_d  = cmd_mode;
            speed_d = cmd_speed;
            state_d = S_LOAD;
        end
    end

    // State, pattern and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_OFF;
            mode_q      <= '0;
            speed_q     <= '0;
            cur_mode_q  <= MODE_OFF;
            pat_q       <= '0;
            dir_right_q <= 1'b0;
            pulse_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            speed_q     <= speed_d;
            cur_mode_q  <= cur_mode_d;
            pat_q       <= pat_d;
            dir_right_q <= dir_right_d;
            pulse_q     <= pulse_d;
        end
    end

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Bench for led_pattern_ctrl: a closed-form pattern/timing model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_led_pattern_ctrl;

    localparam int W    = 16;
    localparam int TDIV = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_mode;
    logic [3:0]  cmd_speed;
    logic [15:0] ledout;
    logic [2:0]  cur_mode;
    logic        step_pulse;

    int errors = 0;
    int checks = 0;

    led_pattern_ctrl #(.WIDTH(W), .TICK_DIV(TDIV)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_mode   (cmd_mode),
        .cmd_speed  (cmd_speed),
        .ledout     (ledout),
        .cur_mode   (cur_mode),
        .step_pulse (step_pulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Pattern after n steps from the initial value, from the mode's definition.
    function automatic logic [15:0] pat(input int mode, input int n);
        int p;
        int pos;
        logic [31:0] v;
        case (mode)
            1: v = 32'd1 << (n % W);
            2: v = 32'd1 << (W - 1 - (n % W));
            3: begin
                p   = n % (2 * (W - 1));
                pos = (p < W) ? p : 2 * (W - 1) - p;
                v   = 32'd1 << pos;
            end
            4: v = (n % 2 == 1) ? 32'h0 : 32'hFFFF;
            5: v = (32'd1 << ((n % W) + 1)) - 32'd1;
            default: v = 32'h0;
        endcase
        return v[15:0];
    endfunction

    // Behavioural model: cycle counting from the load edge.
    logic [15:0] exp_ledout = '0;
    logic [2:0]  exp_mode   = '0;
    logic        exp_pulse  = 1'b0;
    logic        exp_ready  = 1'b1;
    logic [2:0]  m_pend     = '0;
    int          m_pspeed   = 0;
    int          m_speed    = 0;
    int          m_rmode    = 0;
    int          m_n        = 0;
    int          m_cnt      = 0;
    logic        m_loading  = 1'b0;
    logic        m_running  = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_ledout <= '0; exp_mode <= '0; exp_pulse <= 1'b0; exp_ready <= 1'b1;
            m_loading  <= 1'b0; m_running <= 1'b0; m_n <= 0; m_cnt <= 0;
        end else if (m_loading) begin
            m_loading <= 1'b0;
            exp_ready <= 1'b1;
            exp_pulse <= 1'b0;
            m_n       <= 0;
            m_cnt     <= 0;
            m_speed   <= m_pspeed;
            if (m_pend >= 3'd1 && m_pend <= 3'd5) begin
                m_rmode    <= int'(m_pend);
                exp_mode   <= m_pend;
                m_running  <= 1'b1;
                exp_ledout <= pat(int'(m_pend), 0);
            end else begin
                m_rmode    <= 0;
                exp_mode   <= 3'd0;
                m_running  <= 1'b0;
                exp_ledout <= 16'h0;
            end
        end else if (cmd_valid && exp_ready) begin
            m_pend    <= cmd_mode;
            m_pspeed  <= int'(cmd_speed);
            m_loading <= 1'b1;
            exp_ready <= 1'b0;
            exp_pulse <= 1'b0;
            m_running <= 1'b0;
        end else if (m_running) begin
            if (m_cnt + 1 == (m_speed + 1) * TDIV) begin
                m_cnt      <= 0;
                m_n        <= m_n + 1;
                exp_ledout <= pat(m_rmode, m_n + 1);
                exp_pulse  <= 1'b1;
            end else begin
                m_cnt     <= m_cnt + 1;
                exp_pulse <= 1'b0;
            end
        end else begin
            exp_pulse <= 1'b0;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        check("m_ledout", {16'h0, ledout}, {16'h0, exp_ledout});
        check("m_cur_mode", {29'h0, cur_mode}, {29'h0, exp_mode});
        check("m_step_pulse", {31'h0, step_pulse}, {31'h0, exp_pulse});
        check("m_cmd_ready", {31'h0, cmd_ready}, {31'h0, exp_ready});
    end

    // Offer a command for one cycle; returns at the negedge after the accept edge.
    task automatic send(input logic [2:0] mode, input logic [3:0] speed);
        cmd_valid = 1'b1;
        cmd_mode  = mode;
        cmd_speed = speed;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_step(output int waited);
        for (waited = 1; waited <= 200; waited++) begin
            @(negedge clk);
            if (step_pulse) break;
        end
        check("step_seen", {31'h0, step_pulse}, 32'h1);
    endtask

    int w;
    int pulses;
    logic [15:0] left_seq [16] = '{16'h0002, 16'h0004, 16'h0008, 16'h0010,
                                   16'h0020, 16'h0040, 16'h0080, 16'h0100,
                                   16'h0200, 16'h0400, 16'h0800, 16'h1000,
                                   16'h2000, 16'h4000, 16'h8000, 16'h0001};

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_mode = '0; cmd_speed = '0;
        repeat (3) @(negedge clk);
        check("rst_ledout", {16'h0, ledout}, 32'h0);
        check("rst_cur_mode", {29'h0, cur_mode}, 32'h0);
        check("rst_pulse", {31'h0, step_pulse}, 32'h0);
        check("rst_ready", {31'h0, cmd_ready}, 32'h1);
        rst_n = 1'b1;
        @(negedge clk);

        // LEFT, speed 0
        send(3'd1, 4'd0);
        check("left_ready_low", {31'h0, cmd_ready}, 32'h0);
        @(negedge clk);
        check("left_init", {16'h0, ledout}, 32'h0001);
        check("left_mode", {29'h0, cur_mode}, 32'h1);
        check("left_pulse_e1", {31'h0, step_pulse}, 32'h0);
        for (int k = 0; k < 16; k++) begin
            wait_step(w);
            check("left_gap", w, 4);
            check("left_seq", {16'h0, ledout}, {16'h0, left_seq[k]});
        end

        // BOUNCE, speed 1
        send(3'd3, 4'd1);
        @(negedge clk);
        check("bounce_init", {16'h0, ledout}, 32'h0001);
        for (int k = 1; k <= 31; k++) begin
            wait_step(w);
            check("bounce_gap", w, 8);
            if (k == 15) check("bounce_top", {16'h0, ledout}, 32'h8000);
            if (k == 16) check("bounce_turn", {16'h0, ledout}, 32'h4000);
            if (k == 30) check("bounce_bottom", {16'h0, ledout}, 32'h0001);
            if (k == 31) check("bounce_back", {16'h0, ledout}, 32'h0002);
        end

        // FILL then BLINK, speed 0
        send(3'd5, 4'd0);
        @(negedge clk);
        check("fill_init", {16'h0, ledout}, 32'h0001);
        for (int k = 1; k <= 16; k++) begin
            wait_step(w);
            if (k == 1)  check("fill_1", {16'h0, ledout}, 32'h0003);
            if (k == 15) check("fill_full", {16'h0, ledout}, 32'hFFFF);
            if (k == 16) check("fill_wrap", {16'h0, ledout}, 32'h0001);
        end
        send(3'd4, 4'd0);
        @(negedge clk);
        check("blink_init", {16'h0, ledout}, 32'hFFFF);
        wait_step(w);
        check("blink_1", {16'h0, ledout}, 32'h0000);
        wait_step(w);
        check("blink_2", {16'h0, ledout}, 32'hFFFF);

        // LEFT to 0x0010, then RIGHT speed 2 issued on the next step edge
        send(3'd1, 4'd0);
        @(negedge clk);
        for (int k = 0; k < 4; k++) wait_step(w);
        check("coll_pre", {16'h0, ledout}, 32'h0010);
        repeat (3) @(negedge clk);
        send(3'd2, 4'd2);
        check("coll_discard", {16'h0, ledout}, 32'h0010);
        check("coll_no_pulse", {31'h0, step_pulse}, 32'h0);
        check("coll_ready_low", {31'h0, cmd_ready}, 32'h0);
        @(negedge clk);
        check("coll_init", {16'h0, ledout}, 32'h8000);
        check("coll_ready_hi", {31'h0, cmd_ready}, 32'h1);
        check("coll_mode", {29'h0, cur_mode}, 32'h2);
        wait_step(w);
        check("coll_gap", w, 12);
        check("coll_step", {16'h0, ledout}, 32'h4000);

        // Reserved mode 6 behaves as OFF
        send(3'd6, 4'd0);
        @(negedge clk);
        check("rsv_mode", {29'h0, cur_mode}, 32'h0);
        check("rsv_ledout", {16'h0, ledout}, 32'h0);
        pulses = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (step_pulse) pulses++;
        end
        check("rsv_pulses", pulses, 0);

        // Back-to-back: valid held across two commands
        cmd_valid = 1'b1; cmd_mode = 3'd1; cmd_speed = 4'd0;
        @(negedge clk);
        cmd_mode = 3'd2;
        check("b2b_ready_0", {31'h0, cmd_ready}, 32'h0);
        @(negedge clk);
        check("b2b_first", {16'h0, ledout}, 32'h0001);
        check("b2b_first_mode", {29'h0, cur_mode}, 32'h1);
        check("b2b_ready_1", {31'h0, cmd_ready}, 32'h1);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("b2b_ready_2", {31'h0, cmd_ready}, 32'h0);
        @(negedge clk);
        check("b2b_second", {16'h0, ledout}, 32'h8000);
        check("b2b_second_mode", {29'h0, cur_mode}, 32'h2);
        wait_step(w);
        check("b2b_step", {16'h0, ledout}, 32'h4000);

        // Asynchronous reset mid-pattern
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("arst_ledout", {16'h0, ledout}, 32'h0);
        check("arst_ready", {31'h0, cmd_ready}, 32'h1);
        check("arst_mode", {29'h0, cur_mode}, 32'h0);
        check("arst_pulse", {31'h0, step_pulse}, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (step_pulse) pulses++;
        end
        check("arst_no_resume", pulses, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
